// File: rtl/mem_cmd_sequencer_pkg.sv
// Shared memory-controller types: command opcodes, sequencer states and
// the external memory port widths used by the front end and the sequencer.
package mem_ctrl_pkg;

    localparam int MEM_ADDR_W = 25;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_NOP   = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        CLR_REQ,
        DONE
    } seq_state_e;

endpackage

// File: rtl/mem_cmd_sequencer_if.sv
// Command handshake, waitrequest memory bus and response signals of the
// sequencer; master is the front-end/memory side, slave is the sequencer.
interface mem_cmd_sequencer_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_waitrequest;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;
    logic              rsp_done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output mem_waitrequest, mem_rdata, mem_rdata_valid,
        input  cmd_ready, mem_addr, mem_wdata, mem_read, mem_write,
        input  rsp_done, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  mem_waitrequest, mem_rdata, mem_rdata_valid,
        output cmd_ready, mem_addr, mem_wdata, mem_read, mem_write,
        output rsp_done, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/mem_cmd_sequencer_watchdog.sv
// Stall watchdog: counts cycles while run is high and tag is unchanged,
// flagging expiry on the LIMIT-th such cycle.
module mem_seq_watchdog #(
    parameter int LIMIT = 1024,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [TAG_W-1:0] tag,
    output logic             expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    eff;
    logic [TAG_W-1:0] tag_q;

    // A changed tag means a new state or a new clear word: restart at zero.
    assign eff     = (tag != tag_q) ? '0 : cnt;
    assign expired = run && (eff == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            tag_q <= '0;
        end else begin
            tag_q <= tag;
            cnt   <= run ? eff + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/mem_cmd_sequencer.sv
// Command sequencer onto a waitrequest memory bus (clear/read/write/nop).
// Optional stall watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_cmd_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = MEM_ADDR_W,
    parameter int                DATA_W      = MEM_DATA_W,
    parameter logic [ADDR_W-1:0] CLEAR_BASE  = '0,
    parameter logic [ADDR_W-1:0] CLEAR_LAST  = '1,
    parameter int                TIMEOUT_CYC = 1024
) (
    input logic                clk,
    input logic                rst,
    mem_cmd_sequencer_if.slave bus
);
    seq_state_e        state;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic              rsp_done;
    logic [DATA_W-1:0] rsp_rdata;

`ifdef MEM_SEQ_TIMEOUT_EN
    logic rsp_err;
    logic wd_run;
    logic wd_expired;

    assign wd_run = (state == WR_REQ) || (state == RD_REQ) ||
                    (state == RD_WAIT) || (state == CLR_REQ);

    mem_seq_watchdog #(
        .LIMIT (TIMEOUT_CYC),
        .TAG_W (3 + ADDR_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (wd_run),
        .tag     ({state, mem_addr}),
        .expired (wd_expired)
    );

    assign bus.rsp_error = rsp_err;
`else
    assign bus.rsp_error = 1'b0;
`endif

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.rsp_done  = rsp_done;
    assign bus.rsp_rdata = rsp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_done  <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_SEQ_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_done <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            if (wd_expired) begin
                state     <= DONE;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                rsp_done  <= 1'b1;
                rsp_err   <= 1'b1;
            end else
`endif
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
`ifdef MEM_SEQ_TIMEOUT_EN
                        rsp_err <= 1'b0;
`endif
                        unique case (mem_op_e'(bus.cmd_op))
                            OP_WRITE: begin
                                state     <= WR_REQ;
                                mem_write <= 1'b1;
                                mem_addr  <= bus.cmd_addr;
                                mem_wdata <= bus.cmd_wdata;
                            end
                            OP_READ: begin
                                state    <= RD_REQ;
                                mem_read <= 1'b1;
                                mem_addr <= bus.cmd_addr;
                            end
                            OP_CLEAR: begin
                                state     <= CLR_REQ;
                                mem_write <= 1'b1;
                                mem_addr  <= CLEAR_BASE;
                                mem_wdata <= '0;
                            end
                            OP_NOP: begin
                                state    <= DONE;
                                rsp_done <= 1'b1;
                            end
                        endcase
                    end
                end
                WR_REQ: begin
                    if (!bus.mem_waitrequest) begin
                        state     <= DONE;
                        mem_write <= 1'b0;
                        rsp_done  <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!bus.mem_waitrequest) begin
                        mem_read <= 1'b0;
                        if (bus.mem_rdata_valid) begin
                            state     <= DONE;
                            rsp_rdata <= bus.mem_rdata;
                            rsp_done  <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_rdata_valid) begin
                        state     <= DONE;
                        rsp_rdata <= bus.mem_rdata;
                        rsp_done  <= 1'b1;
                    end
                end
                CLR_REQ: begin
                    // Compare before incrementing so an all-ones last address never wraps.
                    if (!bus.mem_waitrequest) begin
                        if (mem_addr == CLEAR_LAST) begin
                            state     <= DONE;
                            mem_write <= 1'b0;
                            rsp_done  <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Randomized bench for mem_cmd_sequencer against a memory/latency model;
// exercises the watchdog path when MEM_SEQ_TIMEOUT_EN is defined.
module tb_mem_cmd_sequencer;
    import mem_ctrl_pkg::*;

    localparam int             AW = 25;
    localparam int             DW = 16;
    localparam logic [AW-1:0]  CB = 25'h10;
    localparam logic [AW-1:0]  CL = 25'h13;
    localparam int             TO = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_cmd_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_cmd_sequencer #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .CLEAR_BASE  (CB),
        .CLEAR_LAST  (CL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            stall_plan[$];
    int            lat_plan[$];
    wr_t           wr_log[$];
    bit            req_open   = 0;
    int            stall_left = 0;
    logic [AW-1:0] open_addr;
    logic [DW-1:0] open_data;
    bit            rd_pending = 0;
    int            rd_cnt     = 0;
    logic [AW-1:0] rd_addr;
    int            acc_req, acc_stalls, acc_lat;
    bit            done_seen;
    int            done_cyc;
    logic [DW-1:0] held_rd = '0;
    logic [AW-1:0] pool [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // One clock: sample at negedge, then drive memory inputs for next edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        chk("strobe_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
        if (bus.rsp_done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        bus.mem_waitrequest = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = DW'($urandom);
        if (req_open) begin
            chk("req_held", {31'b0, bus.mem_read | bus.mem_write}, 32'd1);
            chk("hold_addr", 32'(bus.mem_addr), 32'(open_addr));
            chk("hold_data", 32'(bus.mem_wdata), 32'(open_data));
        end
        if (bus.mem_read || bus.mem_write) begin
            if (!req_open) begin
                req_open   = 1;
                open_addr  = bus.mem_addr;
                open_data  = bus.mem_wdata;
                stall_left = (stall_plan.size() > 0) ? stall_plan.pop_front()
                                                     : int'($urandom_range(0, 3));
                acc_stalls += stall_left;
            end
            if (stall_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                req_open = 0;
                acc_req++;
                if (bus.mem_write) begin
                    wr_log.push_back({bus.mem_addr, bus.mem_wdata});
                    mem_model[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    rd_pending = 1;
                    rd_addr    = bus.mem_addr;
                    rd_cnt     = (lat_plan.size() > 0) ? lat_plan.pop_front()
                                                       : int'($urandom_range(0, 3));
                    acc_lat += rd_cnt;
                end
            end
        end
        if (rd_pending) begin
            if (rd_cnt == 0) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata       = rd_mem(rd_addr);
                rd_pending          = 0;
            end else begin
                rd_cnt--;
            end
        end else if (!bus.mem_read && $urandom_range(0, 3) == 0) begin
            bus.mem_rdata_valid = 1'b1;
        end
    endtask

    task automatic run_cmd(input mem_op_e op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit exp_err);
        int            n;
        int            a;
        int            exp_lat;
        bit            busy_ok;
        logic [DW-1:0] exp_rd;
        wr_t           exp_wr[$];
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            cycle();
            n++;
        end
        chk("ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
        exp_rd = (op == OP_READ && !exp_err) ? rd_mem(addr) : held_rd;
        if (op == OP_WRITE) exp_wr.push_back({addr, wdata});
        if (op == OP_CLEAR)
            for (logic [AW:0] i = {1'b0, CB}; i <= {1'b0, CL}; i++)
                exp_wr.push_back({i[AW-1:0], 16'h0000});
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        a          = cyc;
        acc_req    = 0;
        acc_stalls = 0;
        acc_lat    = 0;
        done_seen  = 0;
        wr_log.delete();
        cycle();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
        busy_ok = 1;
        while (!done_seen && cyc - a < 300) begin
            if (bus.cmd_ready || !bus.busy) busy_ok = 0;
            cycle();
        end
        exp_lat = 1 + acc_req + acc_stalls + (exp_err ? TO : acc_lat);
        chk("done_seen", {31'b0, done_seen}, 32'd1);
        chk("busy_ready", {31'b0, busy_ok}, 32'd1);
        chk("latency", done_cyc - a, exp_lat);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("rsp_error", {31'b0, bus.rsp_error}, {31'b0, exp_err});
        chk("busy_done", {31'b0, bus.busy}, 32'd1);
        chk("ready_done", {31'b0, bus.cmd_ready}, 32'd0);
        chk("wr_cnt", wr_log.size(), exp_wr.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            chk("wr_addr", 32'(wr_log[i].a), 32'(exp_wr[i].a));
            chk("wr_data", 32'(wr_log[i].d), 32'(exp_wr[i].d));
        end
        cycle();
        chk("done_pulse", {31'b0, bus.rsp_done}, 32'd0);
        chk("ready_after", {31'b0, bus.cmd_ready}, 32'd1);
        held_rd = exp_rd;
    endtask

    initial begin
        int k;
        bus.cmd_valid       = 1'b0;
        bus.cmd_op          = 2'b11;
        bus.cmd_addr        = '0;
        bus.cmd_wdata       = '0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_rdata       = '0;
        bus.mem_rdata_valid = 1'b0;
        pool = '{25'h10, 25'h11, 25'h12, 25'h13,
                 25'h1234, 25'h1FFFFFF, 25'h0, 25'h100};

        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rst_read", {31'b0, bus.mem_read}, 32'd0);
        chk("rst_write", {31'b0, bus.mem_write}, 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_done", {31'b0, bus.rsp_done}, 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_error", {31'b0, bus.rsp_error}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        cycle();

        stall_plan.push_back(0);
        run_cmd(OP_WRITE, 25'h0001234, 16'hBEEF, 0);
        stall_plan.push_back(3);
        run_cmd(OP_WRITE, 25'h0000100, 16'h1357, 0);
        mem_model[25'h1FFFFFF] = 16'hA5A5;
        stall_plan.push_back(0);
        lat_plan.push_back(2);
        run_cmd(OP_READ, 25'h1FFFFFF, 16'h0, 0);
        run_cmd(OP_NOP, 25'h0, 16'h0, 0);
        stall_plan = '{0, 2, 0, 0};
        run_cmd(OP_CLEAR, 25'h0, 16'h0, 0);
        stall_plan.push_back(0);
        lat_plan.push_back(0);
        run_cmd(OP_READ, 25'h12, 16'h0, 0);

        for (int i = 0; i < 40; i++) begin
            mem_op_e       op;
            logic [AW-1:0] ad;
            op = mem_op_e'($urandom_range(0, 3));
            ad = $urandom_range(0, 1) ? pool[$urandom_range(0, 7)]
                                      : AW'($urandom);
            run_cmd(op, ad, DW'($urandom), 0);
        end

`ifdef MEM_SEQ_TIMEOUT_EN
        stall_plan.push_back(0);
        lat_plan.push_back(100);
        run_cmd(OP_READ, 25'h55, 16'h0, 1);
        rd_pending = 0;
        run_cmd(OP_WRITE, 25'h56, 16'h7777, 0);
`endif

        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            cycle();
            k++;
        end
        stall_plan = '{0, 0};
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_CLEAR;
        cycle();
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!(bus.mem_write && bus.mem_addr == 25'h11) && k < 20) begin
            cycle();
            k++;
        end
        chk("mid_clear_addr", 32'(bus.mem_addr), 32'h11);
        rst = 1'b1;
        cycle();
        chk("mid_rst_write", {31'b0, bus.mem_write}, 32'd0);
        chk("mid_rst_read", {31'b0, bus.mem_read}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("mid_rst_done", {31'b0, bus.rsp_done}, 32'd0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        req_open   = 0;
        stall_plan.delete();
        held_rd = '0;
        run_cmd(OP_NOP, 25'h0, 16'h0, 0);
        run_cmd(OP_WRITE, 25'h1FFFFFF, 16'h2468, 0);
        run_cmd(OP_READ, 25'h1FFFFFF, 16'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
